// File: rtl/vend_pkg.sv
// Shared types and helpers for the multi-product beverage vending controller.
package vend_pkg;

    typedef enum logic [2:0] {
        POWER_UP = 3'd0,
        IDLE     = 3'd1,
        COLLECT  = 3'd2,
        VEND     = 3'd3,
        RETURN   = 3'd4
    } state_e;

    localparam int unsigned PRICE_LIST_MAX_W = 256;

    // Extracts price idx from a packed list of bal_w-wide entries (entry 0 in the LSBs).
    function automatic logic [31:0] price_of(input logic [PRICE_LIST_MAX_W-1:0] list,
                                             input int unsigned idx,
                                             input int unsigned bal_w);
        logic [PRICE_LIST_MAX_W-1:0] shifted;
        logic [31:0]                 mask;
        shifted = list >> (idx * bal_w);
        mask    = (32'd1 << bal_w) - 32'd1;
        return shifted[31:0] & mask;
    endfunction

endpackage

// File: rtl/beverage_vend_ctrl_if.sv
// Front-end (coin acceptor / keypad) and dispenser signals of the vending controller.
interface beverage_vend_ctrl_if #(
    parameter int unsigned NUM_PRODUCTS = 4,
    parameter int unsigned BAL_W        = 6
);
    localparam int unsigned SEL_W = $clog2(NUM_PRODUCTS);

    logic [1:0]              coin_in;
    logic                    coin_inserted;
    logic [SEL_W-1:0]        select;
    logic                    select_valid;
    logic [NUM_PRODUCTS-1:0] supply_ok;
    logic                    cancel;

    logic                    dispense;
    logic [SEL_W-1:0]        dispense_id;
    logic [BAL_W-1:0]        change;
    logic                    change_valid;
    logic [BAL_W-1:0]        refund;
    logic                    refund_valid;
    logic                    ready;
    logic                    error_no_supply;
    logic                    coin_reject;
    logic [BAL_W-1:0]        balance;

    modport master (
        output coin_in, coin_inserted, select, select_valid, supply_ok, cancel,
        input  dispense, dispense_id, change, change_valid, refund, refund_valid,
               ready, error_no_supply, coin_reject, balance
    );

    modport slave (
        input  coin_in, coin_inserted, select, select_valid, supply_ok, cancel,
        output dispense, dispense_id, change, change_valid, refund, refund_valid,
               ready, error_no_supply, coin_reject, balance
    );

endinterface

// File: rtl/vend_timer.sv
// Loadable down-counter; expire is registered and high whenever the count is zero.
module vend_timer #(
    parameter int unsigned W         = 5,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] count;

    // Counts down to zero and parks there until the next load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= W'(RESET_VAL);
            expire <= (RESET_VAL == 0);
        end else if (load) begin
            count  <= load_val;
            expire <= (load_val == '0);
        end else if (count != '0) begin
            count  <= count - W'(1);
            expire <= (count == W'(1));
        end
    end

endmodule

// File: rtl/beverage_vend_ctrl.sv
// Multi-product vending controller: saturating coin credit, per-product price and supply,
// change on vend, refund on cancel or inactivity.
module beverage_vend_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned                    NUM_PRODUCTS    = 4,
    parameter int unsigned                    BAL_W           = 6,
    parameter logic [NUM_PRODUCTS*BAL_W-1:0]  PRICE_LIST      = {6'd11, 6'd5, 6'd9, 6'd7},
    parameter int unsigned                    TIMEOUT_CYCLES  = 16,
    parameter int unsigned                    DISPENSE_CYCLES = 3,
    parameter int unsigned                    POWERUP_CYCLES  = 4
) (
    input logic                 clk,
    input logic                 reset,
    beverage_vend_ctrl_if.slave bus
);

    localparam int unsigned SEL_W   = $clog2(NUM_PRODUCTS);
    localparam int unsigned MAX_A   = (TIMEOUT_CYCLES > DISPENSE_CYCLES) ? TIMEOUT_CYCLES : DISPENSE_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_A > POWERUP_CYCLES) ? MAX_A : POWERUP_CYCLES;
    localparam int unsigned TW      = $clog2(MAX_CYC + 1);

    // Timer is loaded with N-1 so expire is seen in the N-th cycle after the load.
    localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] DISP_LOAD = TW'(DISPENSE_CYCLES - 1);

    state_e           state, state_n;
    logic [BAL_W-1:0] balance_n, change_n, refund_n, price;
    logic [SEL_W-1:0] dispense_id_n;
    logic             dispense_n, change_valid_n, refund_valid_n, error_n, coin_reject_n, ready_n;
    logic             tmr_load, tmr_expire;
    logic [TW-1:0]    tmr_val;
    logic [BAL_W:0]   coin_sum;
    logic             coin_fits, sel_ok, price_ok;

    vend_timer #(
        .W         (TW),
        .RESET_VAL (POWERUP_CYCLES - 1)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    assign price    = BAL_W'(price_of(PRICE_LIST_MAX_W'(PRICE_LIST), 32'(bus.select), BAL_W));
    assign coin_sum = {1'b0, bus.balance} + (BAL_W+1)'(bus.coin_in);
    assign coin_fits = ~coin_sum[BAL_W];
    assign sel_ok   = ({1'b0, bus.select} < (SEL_W+1)'(NUM_PRODUCTS)) && bus.supply_ok[bus.select];
    assign price_ok = (bus.balance >= price);

    // Next-state and next-output logic; pulses default low, held values default to current.
    always_comb begin
        state_n        = state;
        balance_n      = bus.balance;
        change_n       = bus.change;
        refund_n       = bus.refund;
        dispense_id_n  = bus.dispense_id;
        dispense_n     = 1'b0;
        change_valid_n = 1'b0;
        refund_valid_n = 1'b0;
        error_n        = 1'b0;
        coin_reject_n  = 1'b0;
        tmr_load       = 1'b0;
        tmr_val        = '0;

        case (state)
            POWER_UP: begin
                coin_reject_n = bus.coin_inserted;
                if (tmr_expire) state_n = IDLE;
            end
            IDLE: begin
                if (bus.coin_inserted && (bus.coin_in != 2'd0)) begin
                    balance_n = BAL_W'(bus.coin_in);
                    tmr_load  = 1'b1;
                    tmr_val   = TO_LOAD;
                    state_n   = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.cancel) begin
                    coin_reject_n  = bus.coin_inserted;
                    refund_n       = bus.balance;
                    refund_valid_n = 1'b1;
                    balance_n      = '0;
                    state_n        = RETURN;
                end else if (bus.select_valid && !sel_ok) begin
                    error_n       = 1'b1;
                    coin_reject_n = bus.coin_inserted;
                end else if (bus.select_valid && price_ok) begin
                    coin_reject_n = bus.coin_inserted;
                    dispense_id_n = bus.select;
                    change_n      = bus.balance - price;
                    dispense_n    = 1'b1;
                    tmr_load      = 1'b1;
                    tmr_val       = DISP_LOAD;
                    state_n       = VEND;
                end else if (bus.coin_inserted && coin_fits) begin
                    balance_n = coin_sum[BAL_W-1:0];
                    tmr_load  = 1'b1;
                    tmr_val   = TO_LOAD;
                end else begin
                    coin_reject_n = bus.coin_inserted;
                    if (tmr_expire) begin
                        refund_n       = bus.balance;
                        refund_valid_n = 1'b1;
                        balance_n      = '0;
                        state_n        = RETURN;
                    end
                end
            end
            VEND: begin
                coin_reject_n = bus.coin_inserted;
                dispense_n    = 1'b1;
                if (tmr_expire) begin
                    dispense_n     = 1'b0;
                    change_valid_n = 1'b1;
                    balance_n      = '0;
                    state_n        = IDLE;
                end
            end
            RETURN: begin
                coin_reject_n = bus.coin_inserted;
                state_n       = IDLE;
            end
            default: state_n = POWER_UP;
        endcase

        ready_n = (state_n == IDLE) || (state_n == COLLECT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= POWER_UP;
            bus.dispense        <= 1'b0;
            bus.dispense_id     <= '0;
            bus.change          <= '0;
            bus.change_valid    <= 1'b0;
            bus.refund          <= '0;
            bus.refund_valid    <= 1'b0;
            bus.ready           <= 1'b0;
            bus.error_no_supply <= 1'b0;
            bus.coin_reject     <= 1'b0;
            bus.balance         <= '0;
        end else begin
            state               <= state_n;
            bus.dispense        <= dispense_n;
            bus.dispense_id     <= dispense_id_n;
            bus.change          <= change_n;
            bus.change_valid    <= change_valid_n;
            bus.refund          <= refund_n;
            bus.refund_valid    <= refund_valid_n;
            bus.ready           <= ready_n;
            bus.error_no_supply <= error_n;
            bus.coin_reject     <= coin_reject_n;
            bus.balance         <= balance_n;
        end
    end

endmodule

// File: tb/tb_beverage_vend_ctrl.sv
// Bench for beverage_vend_ctrl: directed scenarios then random traffic against a
// transaction-level model of credit, vending and refunds.
module tb_beverage_vend_ctrl;

    localparam int unsigned N      = 4;
    localparam int unsigned BW     = 6;
    localparam int unsigned TO     = 16;
    localparam int unsigned DC     = 3;
    localparam int unsigned PU     = 4;
    localparam int          MAXBAL = 63;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    beverage_vend_ctrl_if #(.NUM_PRODUCTS(N), .BAL_W(BW)) bus ();

    beverage_vend_ctrl #(
        .NUM_PRODUCTS    (N),
        .BAL_W           (BW),
        .PRICE_LIST      ({6'd11, 6'd5, 6'd9, 6'd7}),
        .TIMEOUT_CYCLES  (TO),
        .DISPENSE_CYCLES (DC),
        .POWERUP_CYCLES  (PU)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int price [N] = '{7, 9, 5, 11};

    // Model: remaining power-up/dispense cycles, credit, idle time since last accepted coin.
    int m_pu, m_bal, m_idle, m_vend, m_id, m_chg, m_ref;
    bit m_sess, m_ret, m_cv, m_rv, m_err, m_rej;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pu = PU; m_bal = 0; m_idle = 0; m_vend = 0; m_id = 0; m_chg = 0; m_ref = 0;
        m_sess = 0; m_ret = 0; m_cv = 0; m_rv = 0; m_err = 0; m_rej = 0;
    endfunction

    function automatic void refund_now();
        m_ref = m_bal; m_rv = 1; m_bal = 0; m_sess = 0; m_ret = 1;
    endfunction

    function automatic void model_step();
        bit coin;
        bit sel;
        int val;
        int idx;
        coin = bus.coin_inserted; sel = bus.select_valid;
        val  = int'(bus.coin_in);  idx = int'(bus.select);
        m_cv = 0; m_rv = 0; m_err = 0; m_rej = 0;
        if (m_pu > 0) begin
            m_rej = coin; m_pu--;
        end else if (m_vend > 0) begin
            m_rej = coin; m_vend--;
            if (m_vend == 0) begin m_cv = 1; m_bal = 0; end
        end else if (m_ret) begin
            m_rej = coin; m_ret = 0;
        end else if (!m_sess) begin
            if (coin && val != 0) begin m_bal = val; m_sess = 1; m_idle = 0; end
        end else if (bus.cancel) begin
            m_rej = coin; refund_now();
        end else if (sel && (idx >= N || !bus.supply_ok[idx])) begin
            m_err = 1; m_rej = coin; m_idle++;
        end else if (sel && m_bal >= price[idx]) begin
            m_rej = coin; m_vend = DC; m_id = idx; m_chg = m_bal - price[idx]; m_sess = 0;
        end else if (coin && m_bal + val <= MAXBAL) begin
            m_bal += val; m_idle = 0;
        end else begin
            m_rej = coin; m_idle++;
            if (m_idle >= TO) refund_now();
        end
    endfunction

    task automatic compare_all();
        check("dispense",        32'(bus.dispense),        32'(m_vend > 0));
        check("dispense_id",     32'(bus.dispense_id),     32'(m_id));
        check("change",          32'(bus.change),          32'(m_chg));
        check("change_valid",    32'(bus.change_valid),    32'(m_cv));
        check("refund",          32'(bus.refund),          32'(m_ref));
        check("refund_valid",    32'(bus.refund_valid),    32'(m_rv));
        check("ready",           32'(bus.ready),           32'(m_pu == 0 && m_vend == 0 && !m_ret));
        check("error_no_supply", 32'(bus.error_no_supply), 32'(m_err));
        check("coin_reject",     32'(bus.coin_reject),     32'(m_rej));
        check("balance",         32'(bus.balance),         32'(m_bal));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        bus.coin_inserted = 1'b0;
        bus.select_valid  = 1'b0;
        bus.cancel        = 1'b0;
    endtask

    task automatic coin(input int v);
        bus.coin_in = 2'(v); bus.coin_inserted = 1'b1; step();
    endtask

    task automatic sel(input int i);
        bus.select = 2'(i); bus.select_valid = 1'b1; step();
    endtask

    task automatic cancel_step();
        bus.cancel = 1'b1; step();
    endtask

    // Reset asserted between edges: outputs must clear immediately, credit is lost.
    task automatic reset_pulse();
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1);
    end

    int r;
    int quiet;

    initial begin
        bus.coin_in = 2'd0; bus.coin_inserted = 1'b0; bus.select = 2'd0;
        bus.select_valid = 1'b0; bus.supply_ok = 4'hF; bus.cancel = 1'b0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;

        // Power-up: coin rejected in cycle 2, ready after four cycles
        step();
        coin(3);
        check("pu_coin_reject", 32'(bus.coin_reject), 32'd1);
        step();
        check("pu_ready_low", 32'(bus.ready), 32'd0);
        step();
        check("pu_ready_high", 32'(bus.ready), 32'd1);

        // Exact payment for product 0
        coin(2); coin(2); coin(3);
        check("t2_balance", 32'(bus.balance), 32'd7);
        sel(0);
        check("t2_dispense", 32'(bus.dispense), 32'd1);
        check("t2_id", 32'(bus.dispense_id), 32'd0);
        step(); step();
        check("t2_dispense_last", 32'(bus.dispense), 32'd1);
        step();
        check("t2_change_valid", 32'(bus.change_valid), 32'd1);
        check("t2_change", 32'(bus.change), 32'd0);
        check("t2_ready", 32'(bus.ready), 32'd1);

        // Overpayment for product 1
        repeat (4) coin(3);
        sel(1);
        check("t3_id", 32'(bus.dispense_id), 32'd1);
        repeat (3) step();
        check("t3_change", 32'(bus.change), 32'd3);
        check("t3_change_valid", 32'(bus.change_valid), 32'd1);

        // Inactivity timeout
        coin(1);
        repeat (TO) step();
        check("t4_refund_valid", 32'(bus.refund_valid), 32'd1);
        check("t4_refund", 32'(bus.refund), 32'd1);
        check("t4_ready_low", 32'(bus.ready), 32'd0);
        step();
        check("t4_ready", 32'(bus.ready), 32'd1);
        check("t4_balance", 32'(bus.balance), 32'd0);

        // Out-of-supply selection, then cancel
        bus.supply_ok = 4'b1011;
        coin(3); coin(3); sel(2);
        check("t5_error", 32'(bus.error_no_supply), 32'd1);
        check("t5_balance", 32'(bus.balance), 32'd6);
        cancel_step();
        check("t5_refund", 32'(bus.refund), 32'd6);
        check("t5_refund_valid", 32'(bus.refund_valid), 32'd1);
        step();
        bus.supply_ok = 4'hF;

        // Zero coin in IDLE, coin colliding with cancel/select, underpaid select
        coin(0);
        check("t6_zero_coin_bal", 32'(bus.balance), 32'd0);
        check("t6_zero_coin_rej", 32'(bus.coin_reject), 32'd0);
        coin(1);
        bus.coin_in = 2'd2; bus.coin_inserted = 1'b1; bus.cancel = 1'b1; step();
        check("t6_cancel_coin_rej", 32'(bus.coin_reject), 32'd1);
        check("t6_cancel_refund", 32'(bus.refund), 32'd1);
        step();
        coin(3); coin(3); coin(3);
        bus.coin_in = 2'd3; bus.coin_inserted = 1'b1; bus.select = 2'd1; bus.select_valid = 1'b1; step();
        check("t6_sel_coin_rej", 32'(bus.coin_reject), 32'd1);
        check("t6_sel_dispense", 32'(bus.dispense), 32'd1);
        repeat (3) step();
        coin(1); sel(3);
        check("t6_underpaid", 32'(bus.dispense), 32'd0);
        cancel_step(); step();

        // Saturation, then reset in the middle of dispensing
        repeat (21) coin(3);
        check("t7_balance_max", 32'(bus.balance), 32'd63);
        coin(1);
        check("t7_overflow_rej", 32'(bus.coin_reject), 32'd1);
        check("t7_balance_hold", 32'(bus.balance), 32'd63);
        sel(3);
        step();
        check("t7_dispensing", 32'(bus.dispense), 32'd1);
        reset_pulse();
        check("t7_abort_dispense", 32'(bus.dispense), 32'd0);
        check("t7_abort_balance", 32'(bus.balance), 32'd0);
        repeat (PU - 1) step();
        check("t7_pu_low", 32'(bus.ready), 32'd0);
        step();
        check("t7_pu_high", 32'(bus.ready), 32'd1);

        // Random traffic against the model
        quiet = 0;
        for (int k = 0; k < 1500; k++) begin
            r = int'($urandom_range(0, 99));
            bus.coin_in = 2'($urandom_range(0, 3));
            bus.select  = 2'($urandom_range(0, 3));
            if (quiet > 0) begin
                quiet--;
                step();
            end else if (r < 40) begin
                coin(int'($urandom_range(1, 3)));
            end else if (r < 55) begin
                sel(int'($urandom_range(0, 3)));
            end else if (r < 58) begin
                cancel_step();
            end else if (r < 61) begin
                quiet = int'($urandom_range(8, 20));
                step();
            end else if (r < 65) begin
                bus.supply_ok = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
                step();
            end else if (r == 99) begin
                reset_pulse();
            end else begin
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
